// File: rtl/fifo16_pkg.sv
// Shared sizing and types for the 16-deep FIFO controller and its RAM.
package fifo16_pkg;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 16;
  localparam int CNT_W  = 5;

  typedef logic [ADDR_W-1:0] ptr_t;
  typedef logic [CNT_W-1:0]  cnt_t;
endpackage

// File: rtl/dpram16xw.sv
// 16xWIDTH dual-port RAM built bit-sliced from 16x1 cells.
module dpram16xw
  import fifo16_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             we,
  input  ptr_t             a,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] spo,
  input  ptr_t             dpra,
  output logic [WIDTH-1:0] dpo
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    ram16x1d u_cell (
      .clk  (clk),
      .we   (we),
      .a    (a),
      .d    (d[i]),
      .spo  (spo[i]),
      .dpra (dpra),
      .dpo  (dpo[i])
    );
  end

endmodule

// File: rtl/ram16x1d.sv
// 16x1 dual-port distributed RAM cell: rising-edge write, asynchronous reads on both ports.
module ram16x1d
  import fifo16_pkg::*;
(
  input  logic clk,
  input  logic we,
  input  ptr_t a,
  input  logic d,
  output logic spo,
  input  ptr_t dpra,
  output logic dpo
);

  logic [DEPTH-1:0] mem;

  always_ff @(posedge clk) begin
    if (we) mem[a] <= d;
  end

  assign spo = mem[a];
  assign dpo = mem[dpra];

endmodule

// File: rtl/ram16_fifo_ctrl.sv
// 16-deep first-word-fall-through FIFO controller: pointers, occupancy, flags and
// error pulses around a 16xWIDTH dual-port RAM (write port at wr_ptr, read port at rd_ptr).
module ram16_fifo_ctrl
  import fifo16_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty,
  output logic             full,
  output logic             half_full,
  output cnt_t             count,
  output logic             overflow,
  output logic             underflow
);

  ptr_t             wr_ptr;
  ptr_t             rd_ptr;
  logic             wr_acc;
  logic             rd_acc;
  logic [WIDTH-1:0] spo_unused;

  // Accepts are gated by the registered flags, so a pop at full still frees
  // a slot only on the next edge and the concurrent write is rejected.
  assign wr_acc = wr_en & ~full  & ~clear;
  assign rd_acc = rd_en & ~empty & ~clear;

  assign empty     = (count == cnt_t'(0));
  assign full      = (count == cnt_t'(DEPTH));
  assign half_full = count[4] | count[3];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (clear) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= wr_en & full;
      underflow <= rd_en & empty;
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  dpram16xw #(.WIDTH(WIDTH)) u_ram (
    .clk  (clk),
    .we   (wr_acc),
    .a    (wr_ptr),
    .d    (wr_data),
    .spo  (spo_unused),
    .dpra (rd_ptr),
    .dpo  (rd_data)
  );

endmodule

// File: tb/tb_ram16_fifo_ctrl.sv
// Bench for ram16_fifo_ctrl: queue scoreboard for data and flags, plus a vector table with explicit counts.
module tb_ram16_fifo_ctrl;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       clear;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       rd_en;
  logic [7:0] rd_data;
  logic       empty;
  logic       full;
  logic       half_full;
  logic [4:0] count;
  logic       overflow;
  logic       underflow;

  int n_chk  = 0;
  int n_pass = 0;
  logic [7:0] q[$];

  typedef struct {
    logic       c;
    logic       w;
    logic       r;
    logic [7:0] d;
    int         exp_cnt;
    logic       exp_ovf;
    logic       exp_udf;
  } vec_t;
  vec_t tbl[$];

  always #5 clk = ~clk;

  ram16_fifo_ctrl #(.WIDTH(8)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .clear     (clear),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .rd_en     (rd_en),
    .rd_data   (rd_data),
    .empty     (empty),
    .full      (full),
    .half_full (half_full),
    .count     (count),
    .overflow  (overflow),
    .underflow (underflow)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  task automatic check_state(input logic eo, input logic eu);
    int n;
    n = q.size();
    chk("count", count, n);
    chk("empty", empty, (n == 0) ? 1 : 0);
    chk("full", full, (n == 16) ? 1 : 0);
    chk("half_full", half_full, (n >= 8) ? 1 : 0);
    chk("overflow", overflow, eo);
    chk("underflow", underflow, eu);
  endtask

  // One clock of stimulus; head word is compared before the edge, state after it.
  task automatic step(input logic c, input logic w, input logic [7:0] d, input logic r);
    logic fm;
    logic em;
    logic eo;
    logic eu;
    @(negedge clk);
    clear = c; wr_en = w; wr_data = d; rd_en = r;
    #1;
    if (q.size() != 0) chk("rd_data", rd_data, q[0]);
    fm = (q.size() == 16);
    em = (q.size() == 0);
    if (c) begin
      q.delete();
      eo = 1'b0;
      eu = 1'b0;
    end else begin
      eo = w & fm;
      eu = r & em;
      if (r && !em) void'(q.pop_front());
      if (w && !fm) q.push_back(d);
    end
    @(posedge clk);
    #1;
    check_state(eo, eu);
    clear = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
  endtask

  function automatic void add(input logic c, input logic w, input logic r, input logic [7:0] d,
                              input int ec, input logic eo, input logic eu);
    vec_t v;
    v.c = c; v.w = w; v.r = r; v.d = d;
    v.exp_cnt = ec; v.exp_ovf = eo; v.exp_udf = eu;
    tbl.push_back(v);
  endfunction

  initial begin
    for (int i = 0; i < 16; i++) add(0, 1, 0, 8'(i), i + 1, 0, 0);
    add(0, 1, 0, 8'hFF, 16, 1, 0);
    add(0, 1, 1, 8'h10, 15, 1, 0);
    add(0, 1, 0, 8'h11, 16, 0, 0);
    for (int i = 0; i < 16; i++) add(0, 0, 1, 8'h00, 15 - i, 0, 0);
    add(0, 1, 1, 8'h22, 1, 0, 1);
    for (int i = 0; i < 6; i++) add(0, 1, 0, 8'(8'h30 + i), 2 + i, 0, 0);
    add(0, 1, 1, 8'h40, 7, 0, 0);
    for (int i = 0; i < 7; i++) add(0, 0, 1, 8'h00, 6 - i, 0, 0);

    reset_n = 1'b0; clear = 1'b0; wr_en = 1'b0; wr_data = 8'h00; rd_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_state(1'b0, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;

    // Underflow on empty must not move rd_ptr.
    step(0, 0, 8'h00, 1);
    step(0, 0, 8'h00, 0);
    step(0, 1, 8'h3C, 0);
    step(0, 0, 8'h00, 1);

    foreach (tbl[i]) begin
      step(tbl[i].c, tbl[i].w, tbl[i].d, tbl[i].r);
      chk("tbl_count", count, tbl[i].exp_cnt);
      chk("tbl_overflow", overflow, tbl[i].exp_ovf);
      chk("tbl_underflow", underflow, tbl[i].exp_udf);
    end

    for (int i = 0; i < 10; i++) step(0, 1, 8'(8'h50 + i), 0);
    for (int i = 0; i < 10; i++) step(0, 0, 8'h00, 1);
    for (int i = 0; i < 10; i++) step(0, 1, 8'(8'h60 + i), 0);
    for (int i = 0; i < 10; i++) step(0, 0, 8'h00, 1);

    // clear beats a concurrent write.
    for (int i = 0; i < 9; i++) step(0, 1, 8'(8'h80 + i), 0);
    step(1, 1, 8'h77, 0);
    chk("clear_count", count, 0);
    chk("clear_empty", empty, 1);
    step(0, 0, 8'h00, 0);
    step(0, 1, 8'h5A, 0);
    chk("post_clear_data", rd_data, 8'h5A);
    step(0, 0, 8'h00, 1);

    // Asynchronous reset in the middle of a cycle with five words stored.
    for (int i = 0; i < 5; i++) step(0, 1, 8'(8'h90 + i), 0);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst_count", count, 0);
    chk("async_rst_empty", empty, 1);
    q.delete();
    @(posedge clk);
    #1;
    check_state(1'b0, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    step(0, 1, 8'hA5, 0);
    chk("post_rst_data", rd_data, 8'hA5);
    step(0, 0, 8'h00, 1);
    step(0, 0, 8'h00, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/ram16_fifo_ctrl.md
# ram16_fifo_ctrl

Synchronous 16-deep FIFO controller that sequences a 16×WIDTH dual-port distributed RAM. The RAM's shared write/read port is driven by the write pointer, and its independent read port by the read pointer. Read data is first-word-fall-through. It serves as the byte buffer between PicoBlaze I/O ports and serial/peripheral logic, and it owns all pointer, occupancy and flag generation.

## Interface
Parameters:
- WIDTH, 8, data word width in bits (1..32).

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  system clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous active-low reset.
- clear  in  1  synchronous flush of pointers and count; stored data is untouched.
- wr_en  in  1  write request, sampled at the rising edge.
- wr_data  in  WIDTH  write data.
- rd_en  in  1  read request; pops the current head word.
- rd_data  out  WIDTH  head word, combinational from the RAM read port at rd_ptr.
- empty  out  1  FIFO holds 0 words.
- full  out  1  FIFO holds 16 words.
- half_full  out  1  count ≥ 8.
- count  out  5  occupancy, 0..16.
- overflow  out  1  one-cycle pulse: wr_en while full.
- underflow  out  1  one-cycle pulse: rd_en while empty.

## Operation
- State: wr_ptr[3:0], rd_ptr[3:0], count[4:0], overflow/underflow registers.
- Write accept: wr_acc = wr_en & ~full.
  - Writes RAM[wr_ptr] ← wr_data.
  - wr_ptr increments mod 16 (15 → 0 wrap).
- Read accept: rd_acc = rd_en & ~empty.
  - rd_ptr increments mod 16.
- Count update:
  - +1 on wr_acc only.
  - −1 on rd_acc only.
  - Unchanged when both or neither are accepted.
- Full and read together: the read is accepted and the write is rejected. The write is gated by the registered full, so count becomes 15 and overflow pulses.
- Empty and write together: the write is accepted and the read is rejected. Count becomes 1 and underflow pulses.
- Flags: empty = (count==0), full = (count==16), half_full = count[4] | count[3]. All decode directly from registered count.
- Gating: the RAM write enable is exactly wr_acc, so the RAM is never written while full.
- Reset (reset_n low, asynchronous): wr_ptr=0, rd_ptr=0, count=0, empty=1, full=0, half_full=0, overflow=0, underflow=0.
  - RAM contents are not reset.
  - rd_data is undefined while empty.
  - Reset mid-operation discards all contents. The first post-reset write lands at address 0.
- clear: same pointer, count and flag effect as reset, but synchronous.
  - clear has priority over wr_en and rd_en in the same cycle: nothing is written and no pulse is raised.
- Storage polarity: the RAM writes on the rising edge of clk. Negative-edge RAM variants are not used.

## Timing
- Write to visible: a word written at edge k appears on rd_data (if it is at the head) and drops empty after edge k. Latency is 1 edge; there is no extra read pipeline.
- Read: rd_data is valid combinationally while ~empty. After the pop edge it shows the next word.
- Flags and count: change only at rising edges, one edge after the causing request.
- overflow/underflow: high for exactly the cycle following the offending edge.
- Throughput: one write and one read per cycle, sustained.

## Structure
- Shared package fifo16_pkg:
  - localparam ADDR_W = 4.
  - localparam DEPTH = 16.
  - localparam CNT_W = 5.
- One sub-module, dpram16xw:
  - Parameter WIDTH.
  - Ports: clk, we, a[3:0], d, spo, dpra[3:0], dpo.
  - Built as WIDTH instances of the 16×1 dual-port distributed RAM primitive.
  - The controller drives a = wr_ptr, dpra = rd_ptr, rd_data = dpo. spo is unused.
- The controller itself holds only pointers, counter, flag decode and pulse registers.

## Test plan
- Reset then idle: reset_n low mid-stream with count=5 → next cycle count=0, empty=1, full=0, half_full=0, pulses 0. Then write 0xA5 → rd_data=0xA5 one edge later.
- Fill and wrap:
  - Write 0x00..0x0F → count=16, full=1, half_full=1 from the 8th write.
  - A 17th write with 0xFF → overflow pulse, count stays 16.
  - Read 16 words → rd_data sequence 0x00..0x0F.
- Pointer wrap: write 10, read 10, write 10 (wr_ptr wraps 15→0 after the 6th) → data read out in order, count tracks exactly.
- Simultaneous:
  - Concurrent write and read at count=7 → count=7.
  - At count=16 → count=15, overflow=1.
  - At count=0 → count=1, underflow=1, rd_data shows the new word.
- Underflow: rd_en on empty after reset → underflow pulse for 1 cycle, rd_ptr unchanged (a following write/read returns the written value).
- clear: at count=9 assert clear together with wr_en=1 → count=0, empty=1, no write, no overflow pulse.
